// File: rtl/compress_line_ctrl_if.sv
// Handshake and data bundle between the line controller, its upstream source,
// the compressor pipeline and the downstream result consumer.
interface compress_line_ctrl_if #(
    parameter int unsigned CACHE_LINE = 128,
    parameter int unsigned WIDTH      = 64
);
    logic                  i_line_valid;
    logic                  o_line_ready;
    logic [CACHE_LINE-1:0] i_line;
    logic [WIDTH-1:0]      o_word;
    logic                  o_word_valid;
    logic                  i_finish;
    logic [CACHE_LINE-1:0] i_mux_array;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [CACHE_LINE-1:0] o_res_line;
    logic                  o_res_raw;
    logic                  o_timeout;
    logic                  o_busy;
    logic [15:0]           o_line_count;

    // Controller side
    modport slave (
        input  i_line_valid, i_line, i_finish, i_mux_array, i_res_ready,
        output o_line_ready, o_word, o_word_valid, o_res_valid, o_res_line,
               o_res_raw, o_timeout, o_busy, o_line_count
    );

    // Environment side (source, compressor, sink)
    modport master (
        output i_line_valid, i_line, i_finish, i_mux_array, i_res_ready,
        input  o_line_ready, o_word, o_word_valid, o_res_valid, o_res_line,
               o_res_raw, o_timeout, o_busy, o_line_count
    );
endinterface

// File: rtl/compress_line_ctrl.sv
// Feeds a cache line to the compressor as two half words, waits a bounded time
// for the packed result and falls back to the raw line if the compressor stalls.
module compress_line_ctrl #(
    parameter int unsigned CACHE_LINE = 128,
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned TIMEOUT    = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    compress_line_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned CNT_W_LAST = TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND_LO = 3'd1,
        S_SEND_HI = 3'd2,
        S_WAIT    = 3'd3,
        S_OUT     = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CACHE_LINE-1:0] line_q, line_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      word_q, word_d;
    logic                  word_valid_q, word_valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  res_valid_q, res_valid_d;
    logic [CACHE_LINE-1:0] res_line_q, res_line_d;
    logic                  res_raw_q, res_raw_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           count_q, count_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_line_q   <= '0;
            res_raw_q    <= 1'b0;
            timeout_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_line_q   <= res_line_d;
            res_raw_q    <= res_raw_d;
            timeout_q    <= timeout_d;
            count_q      <= count_d;
        end
    end

    // Outputs are computed one edge ahead so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        word_d       = '0;
        word_valid_d = 1'b0;
        res_valid_d  = res_valid_q;
        res_line_d   = res_line_q;
        res_raw_d    = res_raw_q;
        timeout_d    = 1'b0;
        count_d      = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_line_valid) begin
                    line_d       = bus.i_line;
                    word_d       = bus.i_line[WIDTH-1:0];
                    word_valid_d = 1'b1;
                    state_d      = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                word_d       = line_q[CACHE_LINE-1:WIDTH];
                word_valid_d = 1'b1;
                state_d      = S_SEND_HI;
            end
            S_SEND_HI: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A finish arriving on the last allowed cycle still counts as success.
                if (bus.i_finish) begin
                    res_line_d  = bus.i_mux_array;
                    res_raw_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else if (cnt_q == CNT_W'(CNT_W_LAST)) begin
                    res_line_d  = line_q;
                    res_raw_d   = 1'b1;
                    res_valid_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.i_res_ready) begin
                    res_valid_d = 1'b0;
                    count_d     = count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign bus.o_line_ready = ready_q;
    assign bus.o_word       = word_q;
    assign bus.o_word_valid = word_valid_q;
    assign bus.o_res_valid  = res_valid_q;
    assign bus.o_res_line   = res_line_q;
    assign bus.o_res_raw    = res_raw_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_line_count = count_q;
endmodule

// File: doc/compress_line_ctrl.md
COMPRESS_LINE_CTRL -- requirements
Module: compress_line_ctrl

Interface
REQ-001 Parameter CACHE_LINE, default 128: uncompressed and compressed line width in bits.
REQ-002 Parameter WIDTH, default 64: width of the word issued to the compressor per cycle (CACHE_LINE/2).
REQ-003 Parameter TIMEOUT, default 12: maximum WAIT cycles allowed for the compressor before raw fallback.
REQ-004 i_clk  input  1  single clock; all state changes on the rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_line_valid  input  1  upstream offers a cache line.
REQ-007 o_line_ready  output  1  controller accepts a line this cycle.
REQ-008 i_line  input  CACHE_LINE  uncompressed cache line.
REQ-009 o_word  output  WIDTH  word driven into the compressor pipeline.
REQ-010 o_word_valid  output  1  o_word carries line data this cycle.
REQ-011 i_finish  input  1  compressor finish pulse (finish_final).
REQ-012 i_mux_array  input  CACHE_LINE  compressor packed output (mux_array2).
REQ-013 o_res_valid  output  1  result line available downstream.
REQ-014 i_res_ready  input  1  downstream accepts the result.
REQ-015 o_res_line  output  CACHE_LINE  compressed line, or the raw line on fallback.
REQ-016 o_res_raw  output  1  o_res_line is the uncompressed fallback.
REQ-017 o_timeout  output  1  one-cycle pulse when the compressor timed out.
REQ-018 o_busy  output  1  high in every state except IDLE.
REQ-019 o_line_count  output  16  number of results delivered; wraps at 16 bits.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, SEND_LO, SEND_HI, WAIT and OUT, all encoded in registers.
REQ-021 o_line_ready SHALL be 1 only in IDLE; there is no back-to-back acceptance from OUT.
REQ-022 In IDLE, when i_line_valid=1, the controller SHALL latch i_line into an internal line register and move to SEND_LO on the next edge.
REQ-023 In SEND_LO, o_word SHALL equal line_reg[WIDTH-1:0] and o_word_valid=1; the next state is SEND_HI.
REQ-024 In SEND_HI, o_word SHALL equal line_reg[CACHE_LINE-1:WIDTH] and o_word_valid=1; the next state is WAIT; the wait counter clears to 0.
REQ-025 In every other state, o_word SHALL be 0 and o_word_valid=0, so the pipeline is flushed with zero words.
REQ-026 In WAIT, the wait counter (width clog2(TIMEOUT)+1) SHALL increment once per cycle.
REQ-027 In WAIT, if i_finish=1, the controller SHALL register i_mux_array into o_res_line, set o_res_raw=0 and move to OUT.
REQ-028 In WAIT, if i_finish=0 and the counter equals TIMEOUT-1:
- o_res_line SHALL take line_reg;
- o_res_raw SHALL be set to 1;
- o_timeout SHALL pulse for one cycle;
- the next state is OUT.
REQ-029 If i_finish=1 in the cycle the timeout condition is reached, finish SHALL win and no timeout SHALL be signalled.
REQ-030 i_finish SHALL be ignored in IDLE, SEND_LO, SEND_HI and OUT.
REQ-031 In OUT, o_res_valid SHALL be 1, and o_res_line and o_res_raw SHALL be held stable until i_res_ready=1.
REQ-032 On the OUT handshake, o_line_count SHALL increment (0xFFFF wraps to 0x0000) and the next state is IDLE.
REQ-033 Acceptance-to-result latency SHALL be 3+N cycles, where N is the number of WAIT cycles up to and including the finish cycle; o_res_valid rises on edge T+3+N after acceptance edge T.
REQ-034 Changes on i_line and i_line_valid after acceptance SHALL NOT affect the line in flight.

Reset
REQ-035 While i_reset=1 at a clock edge, all of the following SHALL hold after that edge:
- state = IDLE;
- o_word = 0, o_word_valid = 0;
- o_res_valid = 0, o_res_line = 0, o_res_raw = 0;
- o_timeout = 0, o_busy = 0, o_line_count = 0;
- wait counter = 0, line_reg = 0.
REQ-036 Reset in any state, including mid-WAIT and OUT, SHALL discard the in-flight line with no result and no timeout pulse.
REQ-037 Reset SHALL take priority over every simultaneous input event.

Verification
REQ-038 Nominal: accept line 0x...FFFF_0000 at cycle 0, i_finish=1 with i_mux_array=0xA5...A5 in the 2nd WAIT cycle -> SEND_LO word low half at cycle 1, high half at cycle 2, o_res_valid at cycle 5 with o_res_line=0xA5...A5, o_res_raw=0.
REQ-039 Backpressure: hold i_res_ready=0 for 4 cycles in OUT -> o_res_line stable, o_line_ready=0, o_line_count increments exactly once after ready.
REQ-040 Timeout: TIMEOUT=12, never assert i_finish -> o_timeout pulses once in the 12th WAIT cycle; o_res_line equals the raw input line; o_res_raw=1.
REQ-041 Simultaneous: i_finish=1 in the 12th WAIT cycle -> compressed result, o_res_raw=0, o_timeout stays 0.
REQ-042 Reset mid-WAIT, then accept a new line -> no result for the first line; second line completes normally; o_line_count=1.
REQ-043 Wrap: preload 65535 deliveries (or force the count) -> the next delivery gives o_line_count=0.
